// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a command byte (LSB first, odd parity, stop) on device clock falls,
// then checks the device ACK. A watchdog aborts a stalled transaction.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | bus released, waiting for send_valid
// S_INHIBIT | host holds CLK low; last cycle also pulls DAT low (start)
// S_REQUEST | CLK released, DAT low, waiting for the first device fall
// S_SHIFT   | presenting data0..7, parity, stop on successive falls
// S_ACK     | waiting for the 11th fall to sample the device ACK bit
// S_RELEASE | waiting for both lines to float high before going idle
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_valid,
  input  logic [7:0] send_data,
  output logic       send_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] BIT_MAX  = 4'd11;
  localparam logic [3:0] BIT_STOP = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SHIFT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t           r_state;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic             r_done;
  logic             r_error;
  logic [INH_W-1:0] r_inh_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [3:0]       r_bit_idx;
  logic [9:0]       r_frame;

  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_dat_s1, r_dat_s2;

  logic       w_fall;
  logic       w_wd_expired;
  logic       w_frame_bit;
  logic [3:0] w_bit_next;

  // Two-flop synchronizers plus a delayed copy of CLK for edge detection;
  // all reset to 1 so an idle bus never looks like a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= ps2_dat_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall       = r_clk_d & ~r_clk_s2;
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_frame_bit  = (r_bit_idx <= BIT_STOP) ? r_frame[r_bit_idx] : 1'b1;
  assign w_bit_next   = (r_bit_idx == BIT_MAX) ? BIT_MAX : r_bit_idx + 4'd1;

  // Transaction FSM with registered line enables and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_inh_cnt <= '0;
      r_wd      <= '0;
      r_bit_idx <= '0;
      r_frame   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (send_valid) begin
            // frame = {stop, odd parity, data}; bit 0 goes out first
            r_frame   <= {1'b1, ~^send_data, send_data};
            r_inh_cnt <= INH_LOAD;
            r_clk_oe  <= 1'b1;
            r_dat_oe  <= 1'b0;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          // falls seen here are our own CLK pull-down, so they are ignored
          if (r_inh_cnt != '0) begin
            r_inh_cnt <= r_inh_cnt - 1'b1;
          end else if (!r_dat_oe) begin
            r_dat_oe <= 1'b1;
          end else begin
            r_clk_oe  <= 1'b0;
            r_bit_idx <= '0;
            r_wd      <= '0;
            r_state   <= S_REQUEST;
          end
        end
        S_REQUEST, S_SHIFT: begin
          if (w_wd_expired) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (w_fall) begin
              r_dat_oe  <= ~w_frame_bit;
              r_bit_idx <= w_bit_next;
              r_state   <= (r_bit_idx == BIT_STOP) ? S_ACK : S_SHIFT;
            end
          end
        end
        S_ACK: begin
          if (w_wd_expired) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (w_fall) begin
              r_done    <= ~r_dat_s2;
              r_error   <= r_dat_s2;
              r_bit_idx <= w_bit_next;
              r_state   <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (w_wd_expired) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (r_clk_s2 && r_dat_s2) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign send_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign done       = r_done;
  assign error      = r_error;

endmodule
